mod_mul_pipe: RTL and testbench

Pipelined, multi-lane modular multiplier: c = a*b mod q, with q picked per transaction (Kyber q=3329 or Dilithium q=8380417). It has a 3-stage elastic pipeline with valid/ready on both sides and backpressure. A sideband tag travels with each transaction. It sits between the NTT butterfly scheduler and the coefficient write-back path.

---
 rtl/mod_pkg.sv | 43 ++++
 rtl/mod_mul_lane.sv | 84 ++++++++
 rtl/mod_mul_pipe.sv | 116 +++++++++++
 tb/tb_mod_mul_pipe.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_pkg.sv
// Shared constants, types and helpers for the pipelined modular multiplier.
// Barrett constants are m = floor(2^k / q); the quotient estimate is low by at most 2.
package mod_pkg;

  localparam int unsigned COEFF_W = 23;
  localparam int unsigned KYB_W   = 12;
  localparam int unsigned PROD_W  = 2 * COEFF_W;
  localparam int unsigned QHAT_W  = 24;

  localparam logic [COEFF_W-1:0] Q_KYBER = 23'd3329;
  localparam logic [COEFF_W-1:0] Q_DIL   = 23'd8380417;

  localparam logic [12:0]        M_KYBER = 13'd5039;
  localparam int unsigned        K_KYBER = 2 * KYB_W;
  localparam logic [QHAT_W-1:0]  M_DIL   = 24'd8396807;
  localparam int unsigned        K_DIL   = PROD_W;

  typedef enum logic {
    MODE_KYBER = 1'b0,
    MODE_DIL   = 1'b1
  } mode_e;

  typedef logic [COEFF_W-1:0] coeff_t;

  function automatic coeff_t q_of(mode_e m);
    return (m == MODE_DIL) ? Q_DIL : Q_KYBER;
  endfunction

  // Range check on the effective operands: Kyber only looks at the low 12 bits.
  function automatic logic out_of_range(mode_e m, coeff_t a, coeff_t b);
    coeff_t a_eff;
    coeff_t b_eff;
    if (m == MODE_DIL) begin
      a_eff = a;
      b_eff = b;
    end else begin
      a_eff = {{(COEFF_W - KYB_W){1'b0}}, a[KYB_W-1:0]};
      b_eff = {{(COEFF_W - KYB_W){1'b0}}, b[KYB_W-1:0]};
    end
    return (a_eff >= q_of(m)) || (b_eff >= q_of(m));
  endfunction

endpackage

// File: rtl/mod_mul_lane.sv
// One lane of the modular multiplier datapath: S1 product, S2 Barrett quotient,
// S3 reduction. Stage enables and per-stage modes come from the parent.
module mod_mul_lane
  import mod_pkg::*;
(
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   en_s1_i,
  input  logic   en_s2_i,
  input  logic   en_s3_i,
  input  mode_e  mode_i,
  input  mode_e  mode_s1_i,
  input  mode_e  mode_s2_i,
  input  coeff_t a_i,
  input  coeff_t b_i,
  output coeff_t c_o
);

  logic [PROD_W-1:0] prod_d, p1_q, p2_q;
  logic [QHAT_W-1:0] qhat_d, qhat_q;
  coeff_t            c_d, c_q;

  // S1: full product for Dilithium, 12x12 product for Kyber
  logic [PROD_W-1:0]  prod_dil;
  logic [2*KYB_W-1:0] prod_kyb;

  always_comb begin
    prod_dil = {{(PROD_W - COEFF_W){1'b0}}, a_i} * {{(PROD_W - COEFF_W){1'b0}}, b_i};
    prod_kyb = {{KYB_W{1'b0}}, a_i[KYB_W-1:0]} * {{KYB_W{1'b0}}, b_i[KYB_W-1:0]};
    prod_d   = (mode_i == MODE_DIL) ? prod_dil
                                    : {{(PROD_W - 2 * KYB_W){1'b0}}, prod_kyb};
  end

  // S2: qhat = (p * m) >> k with the mode-selected constant
  logic [PROD_W+QHAT_W-1:0] bar_dil;
  logic [K_KYBER+12:0]      bar_kyb;

  always_comb begin
    bar_dil = {{QHAT_W{1'b0}}, p1_q} * {{PROD_W{1'b0}}, M_DIL};
    bar_kyb = {13'b0, p1_q[K_KYBER-1:0]} * {{K_KYBER{1'b0}}, M_KYBER};
    qhat_d  = (mode_s1_i == MODE_DIL) ? bar_dil[PROD_W+QHAT_W-1:K_DIL]
                                      : {{(QHAT_W - 13){1'b0}}, bar_kyb[K_KYBER+12:K_KYBER]};
  end

  // S3: remainder is below 3q, so two conditional subtracts suffice
  logic [PROD_W:0]    qq;
  logic [PROD_W-1:0]  diff;
  logic [COEFF_W+1:0] r0, r1, r2, q_ext;
  coeff_t             q3;

  always_comb begin
    q3    = q_of(mode_s2_i);
    q_ext = {2'b0, q3};
    qq    = {{COEFF_W{1'b0}}, qhat_q} * {{QHAT_W{1'b0}}, q3};
    diff  = p2_q - qq[PROD_W-1:0];
    r0    = diff[COEFF_W+1:0];
    r1    = (r0 >= q_ext) ? (r0 - q_ext) : r0;
    r2    = (r1 >= q_ext) ? (r1 - q_ext) : r1;
    c_d   = r2[COEFF_W-1:0];
  end

  logic unused_bits;
  assign unused_bits = ^{bar_dil[K_DIL-1:0], bar_kyb[K_KYBER-1:0], qq[PROD_W],
                         diff[PROD_W-1:COEFF_W+2], r2[COEFF_W+1:COEFF_W]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      p1_q   <= '0;
      p2_q   <= '0;
      qhat_q <= '0;
      c_q    <= '0;
    end else begin
      if (en_s1_i) p1_q <= prod_d;
      if (en_s2_i) begin
        p2_q   <= p1_q;
        qhat_q <= qhat_d;
      end
      if (en_s3_i) c_q <= c_d;
    end
  end

  assign c_o = c_q;

endmodule

// File: rtl/mod_mul_pipe.sv
// Three-stage elastic modular multiplier (Kyber / Dilithium q per transaction).
// Owns the valid/ready chain and the sideband fields; lanes hold only datapath.
module mod_mul_pipe
  import mod_pkg::*;
#(
  parameter int unsigned LANES = 1,
  parameter int unsigned TAG_W = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic                     mode_i,
  input  logic [LANES*COEFF_W-1:0] a_i,
  input  logic [LANES*COEFF_W-1:0] b_i,
  input  logic [TAG_W-1:0]         tag_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [LANES*COEFF_W-1:0] c_o,
  output logic [TAG_W-1:0]         tag_o,
  output logic                     mode_o,
  output logic                     range_err_o,
  output logic                     busy_o
);

  logic v1_q, v2_q, v3_q;
  logic v1_d, v2_d, v3_d;
  logic rdy_s1, rdy_s2, rdy_s3;
  logic en_s1, en_s2, en_s3;

  mode_e            mode_in, mode_s1_q, mode_s2_q, mode_s3_q;
  logic [TAG_W-1:0] tag_s1_q, tag_s2_q, tag_s3_q;
  logic             err_in, err_s1_q, err_s2_q, err_s3_q;

  assign mode_in = mode_e'(mode_i);

  // Ready ripples back from the output so bubbles collapse
  always_comb begin
    rdy_s3 = ~v3_q | out_ready_i;
    rdy_s2 = ~v2_q | rdy_s3;
    rdy_s1 = ~v1_q | rdy_s2;
    en_s1  = in_valid_i & rdy_s1;
    en_s2  = v1_q & rdy_s2;
    en_s3  = v2_q & rdy_s3;
    v1_d   = rdy_s1 ? in_valid_i : v1_q;
    v2_d   = rdy_s2 ? v1_q : v2_q;
    v3_d   = rdy_s3 ? v2_q : v3_q;
  end

  always_comb begin
    err_in = 1'b0;
    for (int unsigned k = 0; k < LANES; k++) begin
      err_in |= out_of_range(mode_in, a_i[k*COEFF_W +: COEFF_W], b_i[k*COEFF_W +: COEFF_W]);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      mode_s1_q <= MODE_KYBER;
      mode_s2_q <= MODE_KYBER;
      mode_s3_q <= MODE_KYBER;
      tag_s1_q  <= '0;
      tag_s2_q  <= '0;
      tag_s3_q  <= '0;
      err_s1_q  <= 1'b0;
      err_s2_q  <= 1'b0;
      err_s3_q  <= 1'b0;
    end else begin
      v1_q <= v1_d;
      v2_q <= v2_d;
      v3_q <= v3_d;
      if (en_s1) begin
        mode_s1_q <= mode_in;
        tag_s1_q  <= tag_i;
        err_s1_q  <= err_in;
      end
      if (en_s2) begin
        mode_s2_q <= mode_s1_q;
        tag_s2_q  <= tag_s1_q;
        err_s2_q  <= err_s1_q;
      end
      if (en_s3) begin
        mode_s3_q <= mode_s2_q;
        tag_s3_q  <= tag_s2_q;
        err_s3_q  <= err_s2_q;
      end
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mod_mul_lane u_lane (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .en_s1_i   (en_s1),
      .en_s2_i   (en_s2),
      .en_s3_i   (en_s3),
      .mode_i    (mode_in),
      .mode_s1_i (mode_s1_q),
      .mode_s2_i (mode_s2_q),
      .a_i       (a_i[k*COEFF_W +: COEFF_W]),
      .b_i       (b_i[k*COEFF_W +: COEFF_W]),
      .c_o       (c_o[k*COEFF_W +: COEFF_W])
    );
  end

  assign in_ready_o  = rdy_s1;
  assign out_valid_o = v3_q;
  assign tag_o       = tag_s3_q;
  assign mode_o      = mode_s3_q;
  assign range_err_o = err_s3_q;
  assign busy_o      = v1_q | v2_q | v3_q;

endmodule

// File: tb/tb_mod_mul_pipe.sv
// Scoreboard bench for mod_mul_pipe: stimulus pushes model results, a monitor
// pops and compares on every output transfer.
module tb_mod_mul_pipe;

  localparam int LANES = 4;
  localparam int TAG_W = 8;
  localparam int DW    = LANES * 23;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             mode = 1'b0;
  logic [DW-1:0]    a = '0;
  logic [DW-1:0]    b = '0;
  logic [TAG_W-1:0] tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [DW-1:0]    c;
  logic [TAG_W-1:0] tag_out;
  logic             mode_out;
  logic             range_err;
  logic             busy;

  int tests = 0;
  int fails = 0;
  bit ready_rand = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic             mode;
    logic [DW-1:0]    c;
    logic             err;
  } exp_t;

  exp_t sb[$];

  mod_mul_pipe #(.LANES(LANES), .TAG_W(TAG_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mode_i      (mode),
    .a_i         (a),
    .b_i         (b),
    .tag_i       (tag),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .c_o         (c),
    .tag_o       (tag_out),
    .mode_o      (mode_out),
    .range_err_o (range_err),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain modular arithmetic on the effective operands
  function automatic exp_t model(input logic m, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                 input logic [TAG_W-1:0] t);
    exp_t e;
    longint unsigned ae, be, q;
    e.tag = t;
    e.mode = m;
    e.c = '0;
    e.err = 1'b0;
    q = m ? 64'd8380417 : 64'd3329;
    for (int k = 0; k < LANES; k++) begin
      ae = m ? 64'(av[k*23 +: 23]) : 64'(av[k*23 +: 12]);
      be = m ? 64'(bv[k*23 +: 23]) : 64'(bv[k*23 +: 12]);
      e.c[k*23 +: 23] = 23'((ae * be) % q);
      if (ae >= q || be >= q) e.err = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [22:0] rand_op(input logic m);
    int unsigned q;
    logic [22:0] r;
    q = m ? 8380417 : 3329;
    case ($urandom_range(0, 4))
      0:       r = 23'($urandom);
      1:       r = 23'($urandom_range(0, q - 1));
      2:       r = 23'(q - 1);
      3:       r = 23'(0);
      default: r = 23'(q + $urandom_range(0, 3));
    endcase
    if (!m && $urandom_range(0, 1) == 1) r = r | (23'($urandom) & 23'h7FF000);
    return r;
  endfunction

  task automatic send(input logic m, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                      input logic [TAG_W-1:0] t);
    int n = 0;
    bit acc = 0;
    mode = m;
    a = av;
    b = bv;
    tag = t;
    in_valid = 1'b1;
    while (!acc && n < 1000) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1;
        sb.push_back(model(m, av, bv, t));
      end
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_accept_timeout", 0, 1);
  endtask

  // Pipeline must be empty: counts edges from the accepting edge to out_valid
  task automatic latency_case(input logic m, input logic [DW-1:0] av, input logic [DW-1:0] bv,
                              input logic [TAG_W-1:0] t);
    int n = 1;
    send(m, av, bv, t);
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency_edges", 128'(n), 128'(3));
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_scoreboard_empty", 128'(sb.size()), 128'(0));
  endtask

  function automatic logic [DW-1:0] rand_vec(input logic m);
    logic [DW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*23 +: 23] = rand_op(m);
    return v;
  endfunction

  // Monitor: compare each output transfer, and check outputs hold while stalled
  logic             prev_stall = 1'b0;
  logic [DW-1:0]    prev_c;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_err;
  exp_t             mon_e;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_hold", 128'(out_valid), 128'(1));
        chk("stall_c_hold", 128'(c), 128'(prev_c));
        chk("stall_tag_hold", 128'(tag_out), 128'(prev_tag));
        chk("stall_err_hold", 128'(range_err), 128'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_output_tag", 128'(tag_out), 128'hDEAD);
        end else begin
          mon_e = sb.pop_front();
          chk("out_c", 128'(c), 128'(mon_e.c));
          chk("out_tag", 128'(tag_out), 128'(mon_e.tag));
          chk("out_mode", 128'(mode_out), 128'(mon_e.mode));
          chk("out_range_err", 128'(range_err), 128'(mon_e.err));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_c     = c;
      prev_tag   = tag_out;
      prev_err   = range_err;
    end
  end

  always @(posedge clk) begin
    #1;
    if (ready_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [DW-1:0] av, bv;
    exp_t e1;

    // Reset state
    #12;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_c", 128'(c), 128'(0));
    chk("rst_tag", 128'(tag_out), 128'(0));
    chk("rst_mode", 128'(mode_out), 128'(0));
    chk("rst_range_err", 128'(range_err), 128'(0));
    #11 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;

    // Kyber 3328*3328, latency check
    av = rand_vec(1'b0);
    bv = rand_vec(1'b0);
    av[22:0] = 23'd3328;
    bv[22:0] = 23'd3328;
    latency_case(1'b0, av, bv, 8'h10);
    drain();

    // Dilithium directed values, back to back
    av = rand_vec(1'b1); bv = rand_vec(1'b1);
    av[22:0] = 23'd8380416; bv[22:0] = 23'd8380416;
    send(1'b1, av, bv, 8'h20);
    av[22:0] = 23'd2; bv[22:0] = 23'd4190209;
    send(1'b1, av, bv, 8'h21);
    av[22:0] = 23'd8380417; bv[22:0] = 23'd5;
    send(1'b1, av, bv, 8'h22);
    // Kyber with upper operand bits set
    av = '0; bv = '0;
    av[22:0] = 23'h0401A4; bv[22:0] = 23'd100;
    send(1'b0, av, bv, 8'h23);
    drain();

    // Backpressure: fill with tags 1..3, tag 4 must be refused
    out_ready = 1'b0;
    av = rand_vec(1'b0); bv = rand_vec(1'b0);
    e1 = model(1'b0, av, bv, 8'd1);
    send(1'b0, av, bv, 8'd1);
    send(1'b1, rand_vec(1'b1), rand_vec(1'b1), 8'd2);
    send(1'b0, rand_vec(1'b0), rand_vec(1'b0), 8'd3);
    av = rand_vec(1'b1); bv = rand_vec(1'b1);
    mode = 1'b1; a = av; b = bv; tag = 8'd4; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("full_in_ready", 128'(in_ready), 128'(0));
      chk("full_busy", 128'(busy), 128'(1));
      chk("stall_tag_is_1", 128'(tag_out), 128'(1));
      chk("stall_c_is_t1", 128'(c), 128'(e1.c));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    fork
      begin
        send(1'b1, av, bv, 8'd4);
        send(1'b0, rand_vec(1'b0), rand_vec(1'b0), 8'd5);
      end
      begin
        repeat (5) begin
          @(negedge clk);
          chk("release_stream_valid", 128'(out_valid), 128'(1));
        end
      end
    join
    drain();

    // Random mixed modes with bubbles and random backpressure
    ready_rand = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        mode = 1'($urandom);
        @(posedge clk);
        #1;
      end
      send(1'(i), rand_vec(1'(i)), rand_vec(1'(i)), 8'(i));
    end
    ready_rand = 0;
    #1;
    out_ready = 1'b1;
    drain();

    // Reset with three transactions in flight
    out_ready = 1'b0;
    send(1'b1, rand_vec(1'b1), rand_vec(1'b1), 8'hA0);
    send(1'b0, rand_vec(1'b0), rand_vec(1'b0), 8'hA1);
    send(1'b1, rand_vec(1'b1), rand_vec(1'b1), 8'hA2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_tag", 128'(tag_out), 128'(0));
    chk("midrst_c", 128'(c), 128'(0));
    sb.delete();
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    chk("after_rst_in_ready", 128'(in_ready), 128'(1));
    latency_case(1'b1, rand_vec(1'b1), rand_vec(1'b1), 8'h55);
    drain();
    repeat (10) @(posedge clk);
    chk("after_rst_idle_valid", 128'(out_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
